// File: rtl/lsu_align_seq.sv
// lsu_align_seq: load/store alignment sequencer between a core and a 32-bit word memory.
// It accepts one byte, halfword or word request and issues one or two word accesses.
// Byte lanes, store data and load data are placed according to the address offset.
// Load data is sign- or zero-extended.
//
// Optional feature: define LSU_MISALIGN_SPLIT_EN to split accesses that cross a word
// boundary into two word accesses. When it is not defined, any access whose offset is
// not a multiple of its size completes immediately with resp_err=1 and touches no memory.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; request fields are req_we, req_size,
//                       req_unsigned, req_addr and req_wdata (LSB-aligned store data)
//   resp_valid          one-cycle completion pulse carrying resp_rdata and resp_err
//                       (all three are registered)
//   mem_rd_en/mem_wr_en word access strobes, carrying mem_addr (word aligned), mem_wdata
//                       and mem_be. These are decoded from the state.
//   mem_rdata           read data, valid in the same cycle as mem_rd_en
module lsu_align_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

  state_t      state_r, state_nxt_s;
  logic        we_r, unsigned_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r, lo_r;
  logic        resp_valid_r, resp_err_r;
  logic [31:0] resp_rdata_r;
  logic [31:0] word_addr_s;
  logic [4:0]  shamt_s;
  logic [63:0] lane_s, rd_word_s;
  logic [7:0]  mask_s;
  logic [31:0] rd_shift_s, load_ext_s;

  // Unshifted lane mask of an access; size 11 has no lanes.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // The access spills into the next word when offset + nbytes > 4.
  function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] nb;
    case (size)
      2'b00:   nb = 4'd1;
      2'b01:   nb = 4'd2;
      2'b10:   nb = 4'd4;
      default: nb = 4'd0;
    endcase
    crosses = (({2'b00, off} + nb) > 4'd4);
  endfunction

  // Requests that complete at once with an error and perform no memory access.
  function automatic logic req_is_err(input logic [1:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    if (size == 2'b11) begin
      req_is_err = 1'b1;
    end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
      req_is_err = 1'b0;
`else
      req_is_err = mis;
`endif
    end
  endfunction

  // Extend the selected low bytes of the load data to 32 bits.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   extend = uns ? {24'h000000, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   extend = uns ? {16'h0000, d[15:0]}   : {{16{d[15]}}, d[15:0]};
      2'b10:   extend = d;
      default: extend = 32'h0000_0000;
    endcase
  endfunction

  // The lane vector and mask span two words; ACC0 uses the low half and ACC1 the high half.
  assign word_addr_s = {addr_r[31:2], 2'b00};
  assign shamt_s     = {addr_r[1:0], 3'b000};
  assign lane_s      = {32'h0000_0000, wdata_r} << shamt_s;
  assign mask_s      = {4'b0000, size_mask(size_r)} << addr_r[1:0];
  assign rd_word_s   = (state_r == ACC1) ? {mem_rdata, lo_r} : {32'h0000_0000, mem_rdata};
  assign rd_shift_s  = 32'(rd_word_s >> shamt_s);
  assign load_ext_s  = extend(rd_shift_s, size_r, unsigned_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; error requests bypass memory and go straight to RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (req_is_err(req_addr[1:0], req_size)) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = ACC0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (crosses(addr_r[1:0], size_r)) begin
          state_nxt_s = ACC1;
        end else begin
          state_nxt_s = RESP;
        end
`else
        state_nxt_s = RESP;
`endif
      end
      ACC1:    state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Memory strobes and handshake, decoded from state and the latched request.
  always_comb begin
    req_ready = (state_r == IDLE);
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_be    = 4'b0000;
    case (state_r)
      ACC0: begin
        mem_rd_en = ~we_r;
        mem_wr_en = we_r;
        mem_addr  = word_addr_s;
        mem_be    = mask_s[3:0];
        mem_wdata = we_r ? lane_s[31:0] : 32'h0000_0000;
      end
      ACC1: begin
        mem_rd_en = ~we_r;
        mem_wr_en = we_r;
        mem_addr  = word_addr_s + 32'd4;  // wraps 0xFFFFFFFC -> 0x00000000
        mem_be    = mask_s[7:4];
        mem_wdata = we_r ? lane_s[63:32] : 32'h0000_0000;
      end
      default: begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
      end
    endcase
  end

  // Request latch, plus capture of the low word of a split load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r       <= 1'b0;
      size_r     <= 2'b00;
      unsigned_r <= 1'b0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      lo_r       <= 32'h0000_0000;
    end else begin
      if ((state_r == IDLE) && req_valid) begin
        we_r       <= req_we;
        size_r     <= req_size;
        unsigned_r <= req_unsigned;
        addr_r     <= req_addr;
        wdata_r    <= req_wdata;
      end
      if ((state_r == ACC0) && !we_r) begin
        lo_r <= mem_rdata;
      end
    end
  end

  // Response registers, loaded on the edge that enters RESP so they are valid during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else if (state_nxt_s == RESP) begin
      resp_valid_r <= 1'b1;
      resp_err_r   <= (state_r == IDLE);  // only error requests reach RESP from IDLE
      resp_rdata_r <= ((state_r == IDLE) || we_r) ? 32'h0000_0000 : load_ext_s;
    end else begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_lsu_align_seq.sv
module tb_lsu_align_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu_align_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Fixed memory contents, addressed by word.
  always_comb begin
    case (mem_addr)
      32'h0000_0100: mem_rdata = 32'h8000_00F0;
      32'h0000_0104: mem_rdata = 32'h1122_3344;
      32'hFFFF_FFFC: mem_rdata = 32'hA1B2_C3D4;
      32'h0000_0000: mem_rdata = 32'h5566_7788;
      default:       mem_rdata = 32'hDEAD_BEEF;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pops the scoreboard; also checks strobe exclusivity.
  always @(negedge clk) begin
    if (rst_n && (mem_rd_en || mem_wr_en)) begin
      chk("rd_wr_exclusive", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b at cycle %0d, expected none",
                 resp_rdata, resp_err, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Issue one request; returns at the negedge of the cycle after acceptance (N+1).
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic push,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_ready_timeout: got 0, expected 1 within 20 cycles");
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    if (push) exp_q.push_back('{exp_rd, exp_err, cyc + lat});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);

    // Aligned word load.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 32'h8000_00F0, 1'b0, 2);
    chk("wl_rd_en", {31'd0, mem_rd_en}, 32'd1);
    chk("wl_be", {28'd0, mem_be}, 32'hF);
    chk("wl_addr", mem_addr, 32'h0000_0100);
    chk("wl_wdata", mem_wdata, 32'h0);
    chk("wl_ready_busy", {31'd0, req_ready}, 32'd0);

    // Byte loads at offset 3, signed and unsigned.
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 2);
    chk("bl_be", {28'd0, mem_be}, 32'h8);
    chk("bl_addr", mem_addr, 32'h0000_0100);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 2);

    // Halfword loads.
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_00F0, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1'b1, 32'hFFFF_8000, 1'b0, 2);
    chk("hl_be", {28'd0, mem_be}, 32'hC);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1'b1, 32'h0000_8000, 1'b0, 2);

    // Stores.
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 2);
    chk("ws_wr_en", {31'd0, mem_wr_en}, 32'd1);
    chk("ws_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("ws_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("ws_be", {28'd0, mem_be}, 32'hF);
    @(negedge clk);
    chk("ws_wr_en_resp", {31'd0, mem_wr_en}, 32'd0);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0105, 32'h0000_00AB, 1'b1, 32'h0, 1'b0, 2);
    chk("bs_be", {28'd0, mem_be}, 32'h2);
    chk("bs_wdata", mem_wdata, 32'h0000_AB00);
    chk("bs_addr", mem_addr, 32'h0000_0104);

    // Illegal size: no memory access, error at N+1.
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 1);
    chk("sz3_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("sz3_rd_en", {31'd0, mem_rd_en}, 32'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Split word load across 0x100/0x104.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 1'b1, 32'h3344_8000, 1'b0, 3);
    chk("sp_acc0_be", {28'd0, mem_be}, 32'hC);
    @(negedge clk);
    chk("sp_acc1_addr", mem_addr, 32'h0000_0104);
    chk("sp_acc1_be", {28'd0, mem_be}, 32'h3);
    // Split halfword store.
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_BEEF, 1'b1, 32'h0, 1'b0, 3);
    chk("ss_acc0_addr", mem_addr, 32'h0000_0200);
    chk("ss_acc0_be", {28'd0, mem_be}, 32'h8);
    chk("ss_acc0_wdata", mem_wdata, 32'hEF00_0000);
    @(negedge clk);
    chk("ss_acc1_addr", mem_addr, 32'h0000_0204);
    chk("ss_acc1_be", {28'd0, mem_be}, 32'h1);
    chk("ss_acc1_wdata", mem_wdata, 32'h0000_00BE);
    // Wrap at the top of the address space.
    issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b1, 32'h7788_A1B2, 1'b0, 3);
    chk("wrap_acc0_addr", mem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_acc1_addr", mem_addr, 32'h0000_0000);
    chk("wrap_acc1_rd_en", {31'd0, mem_rd_en}, 32'd1);
    // Crossing store abandoned by reset in ACC0.
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_BEEF, 1'b0, 32'h0, 1'b0, 0);
`else
    // Misaligned accesses are rejected without touching memory.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 1'b1, 32'h0, 1'b1, 1);
    chk("mis_wl_rd_en", {31'd0, mem_rd_en}, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_BEEF, 1'b1, 32'h0, 1'b1, 1);
    chk("mis_hs_wr_en", {31'd0, mem_wr_en}, 32'd0);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0, 1'b1, 32'h0, 1'b1, 1);
    // Store abandoned by reset in ACC0.
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0BAD_0BAD, 1'b0, 32'h0, 1'b0, 0);
`endif
    chk("mid_wr_en_before", {31'd0, mem_wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_wr_en_reset", {31'd0, mem_wr_en}, 32'd0);
    chk("mid_be_reset", {28'd0, mem_be}, 32'd0);
    chk("mid_addr_reset", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_wr_en_after", {31'd0, mem_wr_en}, 32'd0);

    // Normal operation after the abandoned transaction.
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_00F0, 1'b0, 2);

    repeat (6) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_align_seq.md
LSU_ALIGN_SEQ -- requirements
Module: lsu_align_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: req_valid  in  1  core load/store request.
REQ-004 SHALL have ports: req_we  in  1  1=store, 0=load.
REQ-005 SHALL have ports: req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-006 SHALL have ports: req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
REQ-007 SHALL have ports: req_addr  in  32  byte address; req_wdata  in  32  store data, LSB-aligned.
REQ-008 SHALL have ports: req_ready  out  1  request accepted when req_valid&req_ready.
REQ-009 SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  32  extended load data; resp_err  out  1  error flag.
REQ-010 SHALL have ports: mem_rd_en  out  1; mem_wr_en  out  1; mem_addr  out  32  word-aligned (bits[1:0]=0); mem_wdata  out  32; mem_be  out  4  byte lanes; mem_rdata  in  32  read data, valid same cycle as mem_rd_en.

Function
REQ-011 SHALL implement FSM states IDLE, ACC0, ACC1, RESP.
REQ-012 IDLE: req_ready=1; on accept latch all req_* fields, go to ACC0.
REQ-013 ACC0: drive first word access at {addr[31:2],2'b00}; load captures mem_rdata; go to ACC1 if crossing else RESP.
REQ-014 crossing SHALL be offset+nbytes>4, offset=addr[1:0], nbytes=1/2/4 per size.
REQ-015 ACC1: access word at first word address+4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000); capture high word; go to RESP.
REQ-016 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in ACC0, ACC1, RESP.
REQ-017 latency SHALL be: accept cycle N, resp_valid N+2 (non-crossing), N+3 (crossing).
REQ-018 store: 64-bit lane vector = zero-extended wdata << (8*offset); byte mask = ((1<<nbytes)-1) << offset; ACC0 uses low 32 bits/low 4 mask bits, ACC1 high halves.
REQ-019 load: 64-bit {hi,lo} >> (8*offset), keep nbytes, extend per req_unsigned to 32 bits; mem_be = lane mask on reads too.
REQ-020 mem_rd_en/mem_wr_en SHALL be high only in ACC0/ACC1, never both; mem_wdata=0 on loads.
REQ-021 size 11 SHALL perform no memory access: IDLE->RESP direct, resp_err=1, resp_rdata=0.
REQ-022 store completion SHALL pulse resp_valid with resp_rdata=0.
REQ-023 outputs SHALL be registered except mem_* and req_ready, decoded from state and latched request.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latched request cleared.
REQ-025 during reset mem_rd_en=0, mem_wr_en=0, mem_be=0, mem_addr=0; req_ready=1 from first edge after release.
REQ-026 reset mid-operation SHALL abandon the transaction with no response; an ACC1 half of a store SHALL NOT be issued.

Configuration
REQ-027 macro LSU_MISALIGN_SPLIT_EN defined: crossing accesses split per REQ-013..REQ-019.
REQ-028 macro undefined: any access with offset not multiple of nbytes SHALL skip memory (IDLE->RESP), resp_err=1, resp_rdata=0; ACC1 unreachable.

Verification
REQ-029 aligned word load addr 0x100, mem word 0x8000_00F0 -> mem_be 1111 at N+1, resp_rdata 0x8000_00F0 at N+2.
REQ-030 signed byte load addr 0x103, word 0x80xx_xxxx -> resp_rdata 0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-031 split enabled, halfword store 0xBEEF at addr 0x203 -> ACC0 addr 0x200 be 1000 wdata 0xEF00_0000; ACC1 addr 0x204 be 0001 wdata 0x0000_00BE; resp at N+3.
REQ-032 split disabled, word load at 0x102 -> no mem_rd_en, resp_err=1 at N+1... resp_valid N+1 with rdata 0.
REQ-033 word load at 0xFFFF_FFFE (split on) -> second access mem_addr 0x0000_0000; req_size=11 -> resp_err=1, no memory enable.
REQ-034 rst_n dropped during ACC0 of crossing store -> mem_wr_en low immediately, no ACC1, no resp_valid, req_ready=1 after release.
